// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared state encoding and constants for the binary-to-BCD converter
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd4;
    localparam logic [3:0] ADJ_ADDEND = 4'd3;

    // Counter must hold BIN_W itself, hence the +1.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 correction for one BCD digit before the shift
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit > ADJ_THRESH) ? (digit + ADJ_ADDEND) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative shift-and-add-3 binary-to-BCD converter with saturation and blanking
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W      = 28,
    parameter int NUM_DIGITS = 4,
    parameter int SIGNED     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_bin,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_blank,
    output logic                    out_neg,
    output logic                    out_ovf,
    output logic                    busy
);

    localparam int CW    = cnt_width(BIN_W);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);
    localparam logic [BCD_W-1:0]      ALL_NINES = {NUM_DIGITS{4'h9}};

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [BIN_W-1:0]      mag;
    logic [BIN_W-1:0]      mag_in;
    logic                  neg_in;
    logic [BCD_W-1:0]      bcd;
    logic [BCD_W-1:0]      bcd_adj;
    logic                  ovf_sticky;
    logic                  neg;
    logic                  accept;
    logic                  shift_en;
    logic                  done_en;
    logic                  last_step;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  zero_above;

    // Unary minus at BIN_W bits makes the most negative input come out exact.
    assign neg_in    = (SIGNED != 0) && in_bin[BIN_W-1];
    assign mag_in    = neg_in ? -in_bin : in_bin;
    assign last_step = (cnt == CW'(1));
    assign busy      = ~in_ready;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (bcd[4*d +: 4]),
            .adj   (bcd_adj[4*d +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        done_en   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_en   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
            if (i != 0) begin
                blank_mask[i] = zero_above;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            mag        <= '0;
            bcd        <= '0;
            ovf_sticky <= 1'b0;
            neg        <= 1'b0;
            out_valid  <= 1'b0;
            out_bcd    <= '0;
            out_blank  <= BLANK_RST;
            out_neg    <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                mag        <= mag_in;
                neg        <= neg_in;
                bcd        <= '0;
                ovf_sticky <= 1'b0;
                cnt        <= CW'(BIN_W);
            end
            if (shift_en) begin
                bcd        <= {bcd_adj[BCD_W-2:0], mag[BIN_W-1]};
                mag        <= {mag[BIN_W-2:0], 1'b0};
                ovf_sticky <= ovf_sticky | bcd_adj[BCD_W-1];
                cnt        <= cnt - CW'(1);
            end
            if (done_en) begin
                out_valid <= 1'b1;
                out_neg   <= neg;
                if (ovf_sticky) begin
                    out_bcd   <= ALL_NINES;
                    out_blank <= '0;
                    out_ovf   <= 1'b1;
                end else begin
                    out_bcd   <= bcd;
                    out_blank <= blank_mask;
                    out_ovf   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq (unsigned default and signed 16-bit/5-digit)
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_valid, a_ready, a_ovalid, a_neg, a_ovf, a_busy;
    logic [27:0] a_bin;
    logic [15:0] a_bcd;
    logic [3:0]  a_blank;

    logic        b_valid, b_ready, b_ovalid, b_neg, b_ovf, b_busy;
    logic [15:0] b_bin;
    logic [19:0] b_bcd;
    logic [4:0]  b_blank;

    int checks   = 0;
    int failures = 0;
    int lat;
    int npulse;
    int p_k   [2];
    int p_bcd [2];

    always #5 clk = ~clk;

    bin2bcd_seq dut_a (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .in_bin    (a_bin),
        .out_valid (a_ovalid),
        .out_bcd   (a_bcd),
        .out_blank (a_blank),
        .out_neg   (a_neg),
        .out_ovf   (a_ovf),
        .busy      (a_busy)
    );

    bin2bcd_seq #(.BIN_W(16), .NUM_DIGITS(5), .SIGNED(1)) dut_b (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .in_bin    (b_bin),
        .out_valid (b_ovalid),
        .out_bcd   (b_bcd),
        .out_blank (b_blank),
        .out_neg   (b_neg),
        .out_ovf   (b_ovf),
        .busy      (b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_a(input logic [27:0] v, output int l);
        @(negedge clk);
        a_valid = 1'b1;
        a_bin   = v;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_bin   = 28'hFFFFFFF;
        l = 0;
        while (!a_ovalid && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic run_b(input logic [15:0] v, output int l);
        @(negedge clk);
        b_valid = 1'b1;
        b_bin   = v;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_bin   = 16'h0000;
        l = 0;
        while (!b_ovalid && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_bcd"},   32'(a_bcd),    32'h0);
        chk({tag, "_blank"}, 32'(a_blank),  32'b1110);
        chk({tag, "_neg"},   32'(a_neg),    32'h0);
        chk({tag, "_ovf"},   32'(a_ovf),    32'h0);
        chk({tag, "_valid"}, 32'(a_ovalid), 32'h0);
        chk({tag, "_ready"}, 32'(a_ready),  32'h1);
        chk({tag, "_busy"},  32'(a_busy),   32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_bin   = '0;
        b_valid = 1'b0;
        b_bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        chk("rst_b_blank", 32'(b_blank), 32'b11110);
        @(negedge clk);
        rst_n = 1'b1;

        // basic conversion and latency
        run_a(28'd1234, lat);
        chk("lat_1234",   32'(lat),      32'd29);
        chk("bcd_1234",   32'(a_bcd),    32'h1234);
        chk("blank_1234", 32'(a_blank),  32'b0000);
        chk("ovf_1234",   32'(a_ovf),    32'h0);
        chk("ready_1234", 32'(a_ready),  32'h1);
        @(posedge clk);
        #1;
        chk("pulse_1234", 32'(a_ovalid), 32'h0);
        chk("hold_1234",  32'(a_bcd),    32'h1234);

        // leading-zero blanking
        run_a(28'd7, lat);
        chk("bcd_7",   32'(a_bcd),   32'h0007);
        chk("blank_7", 32'(a_blank), 32'b1110);
        run_a(28'd0, lat);
        chk("bcd_0",   32'(a_bcd),   32'h0000);
        chk("blank_0", 32'(a_blank), 32'b1110);
        run_a(28'd305, lat);
        chk("blank_305", 32'(a_blank), 32'b1000);

        // overflow saturation
        run_a(28'd10000, lat);
        chk("ovf_10000",   32'(a_ovf),   32'h1);
        chk("bcd_10000",   32'(a_bcd),   32'h9999);
        chk("blank_10000", 32'(a_blank), 32'b0000);
        run_a(28'd9999, lat);
        chk("ovf_9999", 32'(a_ovf), 32'h0);
        chk("bcd_9999", 32'(a_bcd), 32'h9999);
        run_a(28'hFFFFFFF, lat);
        chk("ovf_max", 32'(a_ovf), 32'h1);
        chk("neg_max", 32'(a_neg), 32'h0);

        // signed instance
        run_b(16'hFB2E, lat);
        chk("b_lat",        32'(lat),     32'd17);
        chk("b_neg_m1234",  32'(b_neg),   32'h1);
        chk("b_bcd_m1234",  32'(b_bcd),   32'h01234);
        chk("b_blank_m1234",32'(b_blank), 32'b10000);
        run_b(16'h8000, lat);
        chk("b_neg_min", 32'(b_neg), 32'h1);
        chk("b_bcd_min", 32'(b_bcd), 32'h32768);
        chk("b_ovf_min", 32'(b_ovf), 32'h0);
        run_b(16'h7FFF, lat);
        chk("b_neg_max", 32'(b_neg), 32'h0);
        chk("b_bcd_max", 32'(b_bcd), 32'h32767);

        // busy input ignored, then back-to-back accept in the out_valid cycle
        @(negedge clk);
        a_valid = 1'b1;
        a_bin   = 28'd100;
        @(posedge clk);
        #1;
        a_bin  = 28'h2A;
        npulse = 0;
        for (int k = 1; k <= 65; k++) begin
            @(posedge clk);
            #1;
            if (k == 30) a_valid = 1'b0;
            if (a_ovalid) begin
                if (npulse < 2) begin
                    p_k[npulse]   = k;
                    p_bcd[npulse] = 32'(a_bcd);
                end
                npulse++;
            end
            if (k == 29) chk("b2b_ready", 32'(a_ready), 32'h1);
        end
        chk("b2b_npulse", 32'(npulse), 32'd2);
        if (npulse >= 2) begin
            chk("b2b_k0",   32'(p_k[0]),   32'd29);
            chk("b2b_bcd0", 32'(p_bcd[0]), 32'h0100);
            chk("b2b_k1",   32'(p_k[1]),   32'd59);
            chk("b2b_bcd1", 32'(p_bcd[1]), 32'h0042);
        end

        // reset mid-conversion
        @(negedge clk);
        a_valid = 1'b1;
        a_bin   = 28'd4321;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", 32'(a_ready), 32'h1);
        npulse = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (a_ovalid) npulse++;
        end
        chk("midrst_no_valid", 32'(npulse), 32'd0);
        run_a(28'd5678, lat);
        chk("lat_5678", 32'(lat),   32'd29);
        chk("bcd_5678", 32'(a_bcd), 32'h5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, iterative binary-to-BCD converter (shift-and-add-3) with a valid/ready input handshake, optional signed input, overflow saturation and a leading-zero blank mask. It sits between an arithmetic result source (calculator core, counters) and the seven-segment display driver, and generalises the fixed 28-bit/4-digit converter to any input width and digit count.

## Interface
- `BIN_W`, default 28: binary input width, at least 2.
- `NUM_DIGITS`, default 4: BCD digits produced, at least 1.
- `SIGNED`, default 0: 1 means `in_bin` is two's complement.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: synchronous, active-low reset.
- `in_valid` input, 1 bit: `in_bin` is valid.
- `in_ready` output, 1 bit: the block accepts input this cycle.
- `in_bin` input, `BIN_W` bits: value to convert.
- `out_valid` output, 1 bit: one-cycle pulse when a new result is present.
- `out_bcd` output, `4*NUM_DIGITS` bits: BCD result; digit *i* is in bits [4i+3:4i]; digit 0 is the least significant.
- `out_blank` output, `NUM_DIGITS` bits: bit *i* is 1 when digit *i* is a leading zero.
- `out_neg` output, 1 bit: the input was negative (`SIGNED=1` only, otherwise 0).
- `out_ovf` output, 1 bit: the magnitude is at least 10^`NUM_DIGITS`.
- `busy` output, 1 bit: a conversion is in progress (equal to `~in_ready`).

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - When `in_valid` is 1: latch the magnitude, clear the BCD field, clear the sticky overflow bit, set the counter to `BIN_W`, and go to SHIFT.
- **Magnitude and sign:**
  - With `SIGNED=1` and the MSB set, magnitude = `-in_bin`, computed as a `BIN_W`-bit unsigned value, so -2^(`BIN_W`-1) is exact.
  - The sign is latched at accept.
- **SHIFT, once per cycle:**
  1. Every BCD digit greater than 4 gets +3.
  2. Shift {BCD, magnitude} left by 1.
  3. OR the bit shifted out of the top digit into the sticky overflow bit.
  4. Decrement the counter. After `BIN_W` steps, go to DONE.
- **DONE:**
  - Register the outputs and pulse `out_valid`, then return to IDLE.
  - If overflow is set: `out_bcd` is all 9s, `out_blank` = 0, `out_ovf` = 1.
  - Otherwise `out_bcd` is the BCD field.
  - `out_blank[i]` = 1 when digit *i* and all higher digits are zero, for *i* ≥ 1. `out_blank[0]` is always 0.
  - `out_neg` is the latched sign, and is kept even on overflow.
- **Output holding:** outputs hold their values until the next DONE. `out_valid` is high for exactly one cycle.
- **Input while busy:** `in_valid` while busy is ignored, with no queuing. `in_bin` is sampled only on the accept edge.

## Timing
- **Reset values:**
  - `out_bcd` = 0, `out_blank` = all ones except bit 0 (shows "0").
  - `out_neg` = 0, `out_ovf` = 0, `out_valid` = 0.
  - `in_ready` = 1, `busy` = 0, FSM in IDLE.
- **Latency:** accept edge E0; shift steps on edges E1..E`BIN_W`; outputs and `out_valid` registered on edge E(`BIN_W`+1). Default parameters: 29 cycles.
- **Ready:** `in_ready` falls after E0 and rises again in the same cycle that `out_valid` is high. A new accept is allowed in that cycle (back-to-back). Throughput is one conversion per `BIN_W`+2 cycles.
- **Reset mid-conversion:** aborts immediately. All outputs return to their reset values with no `out_valid`, and `in_ready` is 1 in the first cycle after release.
- **Counter width:** `$clog2(BIN_W+1)`.
- **BCD field width:** `4*NUM_DIGITS`, plus 1 sticky overflow bit.

## Structure
- **Package `bin2bcd_pkg`:**
  - FSM state encoding: IDLE=0, SHIFT=1, DONE=2.
  - BCD adjust threshold (4) and addend (3) constants.
  - Counter-width helper function.
- **Sub-module `bcd_digit_adj`:**
  - Combinational: 4-bit digit in, digit+3 out if >4, else unchanged.
  - Instantiated `NUM_DIGITS` times in a generate loop.
- **Top level:** the FSM, the datapath shift register, the overflow/sign registers and the blank-mask logic.

## Test plan
1. **Basic conversion:** defaults, accept 1234 → exactly 29 cycles later `out_valid`=1 for 1 cycle, `out_bcd`=0x1234, `out_blank`=4'b0000, `out_ovf`=0.
2. **Leading-zero blanking:** accept 7 → `out_bcd`=0x0007, `out_blank`=4'b1110. Accept 0 → `out_bcd`=0x0000, `out_blank`=4'b1110.
3. **Overflow:** accept 10000 → `out_ovf`=1, `out_bcd`=0x9999, `out_blank`=0. Accept 9999 → `out_ovf`=0, `out_bcd`=0x9999.
4. **Signed input:** `SIGNED=1`, `BIN_W=16`, `NUM_DIGITS=5`.
   - 0xFB2E → `out_neg`=1, `out_bcd`=0x01234, `out_blank`=5'b10000, latency 17.
   - 0x8000 → `out_neg`=1, `out_bcd`=0x32768.
5. **Busy and back-to-back:** while busy, `in_valid` held with 0x2A → ignored, with only one `out_valid` for the first value. Present 42 in the `out_valid` cycle → accepted, with its result 29 cycles later.
6. **Reset mid-conversion:** reset low on cycle 10 of a conversion → no `out_valid`, outputs at reset values, `in_ready`=1 in the first cycle after release. The next conversion of 5678 gives 0x5678.
